inst_feeder: RTL and testbench

- Instruction-issue initiator for the 16-bit multicycle processor: fetches words from a synchronous instruction ROM and presents each on the processor's DIN with a one-cycle Run pulse.
- Waits for the processor's Done before issuing the next word; stops after a programmed count or on a Done timeout.
- Sits between the instruction ROM and the processor core, in the same Clock domain.

---
 rtl/inst_feeder_pkg.sv | 25 ++
 rtl/inst_feeder_regn.sv | 20 ++
 rtl/inst_feeder.sv | 137 +++++++++++++
 tb/tb_inst_feeder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_feeder_pkg.sv
// Shared definitions for the instruction feeder, the processor it drives and the bench.
package inst_feeder_pkg;

  // Feeder FSM state encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Processor opcodes, found in instruction bits [15:13].
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // mv/mvt finish in T1; add/sub need the full T0..T3 sequence.
  function automatic logic is_two_step(input logic [2:0] op);
    return (op == OP_MV) || (op == OP_MVT);
  endfunction

endpackage

// File: rtl/inst_feeder_regn.sv
// Enable-gated n-bit register with synchronous active-low clear.
module regn #(
  parameter int n = 16
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  // Load d when enabled, otherwise hold; reset clears to zero.
  always_ff @(posedge clock) begin
    if (!resetn)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/inst_feeder.sv
// Instruction feeder: reads words from a synchronous ROM and issues them to the
// multicycle processor one at a time, waiting for Done between issues.
//
// state | meaning
// IDLE  | waiting for Go
// FETCH | MemAddr = Pc presented to the ROM
// LOAD  | ROM word valid on MemQ, captured into DIN
// ISSUE | Run high for one cycle, processor takes DIN
// WAIT  | waiting for Done, bounded by TIMEOUT cycles
// FIN   | one-cycle Finished pulse, then back to IDLE
module inst_feeder
  import inst_feeder_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Go,
  input  logic [ADDR_W:0]   Len,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemQ,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Finished,
  output logic              Error
);

  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W:0]     issued;
  logic [ADDR_W:0]     issued_inc;
  logic [ADDR_W:0]     len_q;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                error_q;
  logic                din_en;

  assign issued_inc = issued + 1'b1;
  assign MemAddr    = pc;
  assign Error      = error_q;

  // State register.
  always_ff @(posedge Clock) begin
    if (!Resetn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt = state;
    Run       = 1'b0;
    Busy      = 1'b1;
    Finished  = 1'b0;
    din_en    = 1'b0;
    case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Go)
          state_nxt = (Len == '0) ? S_FIN : S_FETCH;
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        din_en    = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        Run       = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (Done)
          state_nxt = (issued_inc == len_q) ? S_FIN : S_FETCH;
        else if (wait_cnt == WAIT_LAST)
          state_nxt = S_FIN;
      end
      S_FIN: begin
        Finished  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Program counter, issue count, Done watchdog and sticky error.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pc       <= '0;
      issued   <= '0;
      len_q    <= '0;
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Go) begin
            len_q   <= Len;
            pc      <= '0;
            issued  <= '0;
            error_q <= 1'b0;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (Done) begin
            pc       <= pc + 1'b1;
            issued   <= issued_inc;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // DIN holds the issued word from LOAD until the next LOAD.
  regn #(.n(DATA_W)) u_din (
    .clock  (Clock),
    .resetn (Resetn),
    .en     (din_en),
    .d      (MemQ),
    .q      (DIN)
  );

endmodule

// File: tb/tb_inst_feeder.sv
// Scoreboard bench for inst_feeder with a behavioural ROM and processor.
module tb_inst_feeder;
  import inst_feeder_pkg::*;

  logic        Clock;
  logic        Resetn;
  logic        Go;
  logic [5:0]  Len;
  logic [4:0]  MemAddr;
  logic [15:0] MemQ;
  logic [15:0] DIN;
  logic        Run;
  logic        Done;
  logic        Busy;
  logic        Finished;
  logic        Error;

  inst_feeder #(.ADDR_W(5), .DATA_W(16), .TIMEOUT(8)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Go       (Go),
    .Len      (Len),
    .MemAddr  (MemAddr),
    .MemQ     (MemQ),
    .DIN      (DIN),
    .Run      (Run),
    .Done     (Done),
    .Busy     (Busy),
    .Finished (Finished),
    .Error    (Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous ROM.
  logic [15:0] rom [0:31];
  always @(posedge Clock) MemQ <= rom[MemAddr];

  // Behavioural processor: captures DIN on Run, Done in T1 (mv/mvt) or T3 (add/sub).
  logic        proc_en;
  logic        proc_clr;
  logic [1:0]  step;
  logic [15:0] ir;
  logic [15:0] r [0:7];
  logic [15:0] opnd;

  always_comb begin
    Done = 1'b0;
    if (proc_en && step != 2'd0)
      Done = is_two_step(ir[15:13]) ? (step == 2'd1) : (step == 2'd3);
    opnd = ir[12] ? {7'b0, ir[8:0]} : r[ir[2:0]];
  end

  always @(posedge Clock) begin
    if (!Resetn || !proc_en) begin
      step <= 2'd0;
    end else if (step == 2'd0) begin
      if (Run) begin
        ir   <= DIN;
        step <= 2'd1;
      end
    end else if (Done) begin
      step <= 2'd0;
      case (ir[15:13])
        OP_MV:   r[ir[11:9]] <= opnd;
        OP_MVT:  r[ir[11:9]] <= {ir[7:0], 8'h00};
        OP_ADD:  r[ir[11:9]] <= r[ir[11:9]] + opnd;
        OP_SUB:  r[ir[11:9]] <= r[ir[11:9]] - opnd;
        default: ;
      endcase
    end else begin
      step <= step + 2'd1;
    end
    if (proc_clr)
      for (int i = 0; i < 8; i++) r[i] <= 16'h0;
  end

  // Scoreboard.
  typedef struct {
    bit          is_fin;
    logic [15:0] din;
    logic [4:0]  pc;
    int          gap;
    bit          from_go;
    bit          err;
    int          busy;
    bit          chk_regs;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] r2;
  } exp_t;

  exp_t q[$];
  exp_t em;
  int   passed = 0;
  int   total  = 0;
  int   cyc = 0;
  int   go_cyc = 0;
  int   last_run_cyc = 0;
  int   busy_cnt = 0;
  logic run_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got === req)
      passed++;
    else
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, req, $time);
  endtask

  task automatic push_run(input logic [15:0] din, input logic [4:0] pc, input int gap, input bit from_go);
    exp_t e;
    e = '{default: '0};
    e.din = din; e.pc = pc; e.gap = gap; e.from_go = from_go;
    q.push_back(e);
  endtask

  task automatic push_fin(input int gap, input bit from_go, input bit err, input logic [4:0] pc,
                          input int busy, input bit chk_regs,
                          input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2);
    exp_t e;
    e = '{default: '0};
    e.is_fin = 1'b1; e.gap = gap; e.from_go = from_go; e.err = err; e.pc = pc;
    e.busy = busy; e.chk_regs = chk_regs; e.r0 = r0; e.r1 = r1; e.r2 = r2;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per Run or Finished pulse and compares.
  always @(posedge Clock) begin
    #1;
    cyc++;
    if (!Resetn) begin
      busy_cnt = 0;
    end else begin
      if (Busy) busy_cnt++;
      if (Run) begin
        chk("run_not_consecutive", run_prev, 1'b0);
        if (q.size() == 0) begin
          chk("unexpected_run", Run, 1'b0);
        end else begin
          em = q.pop_front();
          chk("run_expected_here", Run, !em.is_fin);
          if (!em.is_fin) begin
            chk("run_din", DIN, em.din);
            chk("run_memaddr", MemAddr, em.pc);
            chk("run_gap", cyc - (em.from_go ? go_cyc : last_run_cyc), em.gap);
          end
        end
        last_run_cyc = cyc;
      end
      if (Finished) begin
        if (q.size() == 0) begin
          chk("unexpected_finished", Finished, 1'b0);
        end else begin
          em = q.pop_front();
          chk("finished_expected_here", Finished, em.is_fin);
          if (em.is_fin) begin
            chk("fin_gap", cyc - (em.from_go ? go_cyc : last_run_cyc), em.gap);
            chk("fin_error", Error, em.err);
            chk("fin_memaddr", MemAddr, em.pc);
            chk("fin_busy_cycles", busy_cnt, em.busy);
            if (em.chk_regs) begin
              chk("fin_r0", r[0], em.r0);
              chk("fin_r1", r[1], em.r1);
              chk("fin_r2", r[2], em.r2);
            end
          end
        end
        busy_cnt = 0;
      end
    end
    run_prev = Run;
  end

  // Stimulus helpers; all start and end on a falling edge.
  task automatic start(input logic [5:0] len, input bit hold);
    Len    = len;
    Go     = 1'b1;
    go_cyc = cyc;
    if (!hold) begin
      @(negedge Clock);
      Go = 1'b0;
    end
  endtask

  task automatic wait_fin(input int max);
    int n;
    n = 0;
    while (!Finished && n < max) begin
      @(negedge Clock);
      n++;
    end
    if (!Finished) chk("wait_fin_timeout", Finished, 1'b1);
  endtask

  task automatic clear_proc();
    proc_clr = 1'b1;
    @(negedge Clock);
    proc_clr = 1'b0;
  endtask

  initial begin
    int seen;
    int n;
    Resetn   = 1'b0;
    Go       = 1'b0;
    Len      = '0;
    proc_en  = 1'b1;
    proc_clr = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0;

    repeat (3) @(posedge Clock);
    #1;
    chk("reset_run", Run, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_finished", Finished, 1'b0);
    chk("reset_error", Error, 1'b0);
    chk("reset_din", DIN, 16'h0);
    chk("reset_memaddr", MemAddr, 5'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    clear_proc();

    // Basic run: mv r0,#5 ; mv r1,r0 ; mvt r2,#1
    rom[0] = 16'h1005; rom[1] = 16'h0200; rom[2] = 16'h3401;
    push_run(16'h1005, 5'd0, 3, 1'b1);
    push_run(16'h0200, 5'd1, 4, 1'b0);
    push_run(16'h3401, 5'd2, 4, 1'b0);
    push_fin(2, 1'b0, 1'b0, 5'd3, 13, 1'b1, 16'h0005, 16'h0005, 16'h0100);
    start(6'd3, 1'b0);
    wait_fin(60);
    @(negedge Clock);
    clear_proc();

    // Add/sub timing: mv r0,#3 ; add r0,#4 ; sub r0,#2
    rom[0] = 16'h1003; rom[1] = 16'h5004; rom[2] = 16'h7002;
    push_run(16'h1003, 5'd0, 3, 1'b1);
    push_run(16'h5004, 5'd1, 4, 1'b0);
    push_run(16'h7002, 5'd2, 6, 1'b0);
    push_fin(4, 1'b0, 1'b0, 5'd3, 17, 1'b1, 16'h0005, 16'h0000, 16'h0000);
    start(6'd3, 1'b0);
    wait_fin(60);
    @(negedge Clock);

    // Timeout: no Done ever arrives.
    proc_en = 1'b0;
    push_run(16'h1003, 5'd0, 3, 1'b1);
    push_fin(9, 1'b0, 1'b1, 5'd0, 12, 1'b0, 16'h0, 16'h0, 16'h0);
    start(6'd2, 1'b0);
    wait_fin(60);
    @(negedge Clock);
    chk("error_sticky_in_idle", Error, 1'b1);
    proc_en = 1'b1;
    push_run(16'h1003, 5'd0, 3, 1'b1);
    push_fin(2, 1'b0, 1'b0, 5'd1, 5, 1'b0, 16'h0, 16'h0, 16'h0);
    start(6'd1, 1'b0);
    chk("error_cleared_by_go", Error, 1'b0);
    wait_fin(60);
    @(negedge Clock);

    // Wrap with Go held high: Len = 33 re-issues address 0.
    for (int i = 0; i < 32; i++) rom[i] = 16'h1600 | 16'(i);
    for (int k = 0; k < 33; k++)
      push_run(16'h1600 | 16'(k % 32), 5'(k % 32), (k == 0) ? 3 : 4, k == 0);
    push_fin(2, 1'b0, 1'b0, 5'd1, 133, 1'b0, 16'h0, 16'h0, 16'h0);
    start(6'd33, 1'b1);
    wait_fin(400);
    Go = 1'b0;
    repeat (6) @(negedge Clock);
    chk("wrap_no_restart_busy", Busy, 1'b0);

    // Reset during the WAIT of instruction 2.
    rom[0] = 16'h1005; rom[1] = 16'h0200; rom[2] = 16'h3401;
    push_run(16'h1005, 5'd0, 3, 1'b1);
    push_run(16'h0200, 5'd1, 4, 1'b0);
    start(6'd3, 1'b0);
    seen = 0;
    n = 0;
    while (seen < 2 && n < 40) begin
      @(negedge Clock);
      n++;
      if (Run) seen++;
    end
    chk("reset_test_reached_run2", seen, 2);
    @(negedge Clock);
    Resetn = 1'b0;
    @(posedge Clock);
    #1;
    chk("midrun_reset_run", Run, 1'b0);
    chk("midrun_reset_busy", Busy, 1'b0);
    chk("midrun_reset_din", DIN, 16'h0);
    chk("midrun_reset_memaddr", MemAddr, 5'd0);
    chk("midrun_reset_finished", Finished, 1'b0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);

    // Len = 0: straight to FIN, no fetch and no issue.
    push_fin(1, 1'b1, 1'b0, 5'd0, 1, 1'b0, 16'h0, 16'h0, 16'h0);
    start(6'd0, 1'b0);
    wait_fin(10);
    repeat (4) @(negedge Clock);
    chk("len0_idle_after", Busy, 1'b0);

    repeat (3) @(negedge Clock);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
